// File: rtl/text_line_drawer.sv
// Walks a character buffer and hands one glyph at a time to symbol_drawer, advancing x per glyph.
// Latency: 5 cycles per glyph plus the symbol_drawer draw time. Backpressure: holds each glyph until sd_ready.
module text_line_drawer #(
    parameter int MAX_LEN        = 32,
    parameter int SYMBOL_ADVANCE = 15,
    parameter int SCREEN_WIDTH   = 640,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int AW = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          ready,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    input  logic [LW-1:0] length,
    input  logic [LW-1:0] cursor_pos,
    output logic [AW-1:0] text_read_addr,
    input  logic [6:0]    text_read_data,
    output logic          sd_start,
    input  logic          sd_ready,
    output logic [9:0]    sd_x,
    output logic [8:0]    sd_y,
    output logic [6:0]    sd_symbol,
    output logic          sd_cursor_left,
    output logic          sd_cursor_right
);

    localparam logic [10:0] ADV   = 11'(SYMBOL_ADVANCE);
    localparam logic [10:0] LIMIT = 11'(SCREEN_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_CLIP, S_ISSUE, S_SETTLE, S_WAIT, S_EMPTY
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   cur_x_q, cur_x_d;
    logic [8:0]    y_q, y_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cur_q, cur_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [6:0]    sym_q, sym_d;
    logic          left_q, left_d;
    logic          right_q, right_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_x_q <= '0;
            y_q     <= '0;
            len_q   <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            sym_q   <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            y_q     <= y_d;
            len_q   <= len_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        y_d     = y_q;
        len_d   = len_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        left_d  = left_q;
        right_d = right_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_x_d = {1'b0, x};
                    y_d     = y;
                    len_d   = length;
                    cur_d   = cursor_pos;
                    idx_d   = '0;
                    state_d = (length != '0) ? S_FETCH : S_EMPTY;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                sym_d   = text_read_data;
                left_d  = (cur_q == idx_q);
                // idx+1==len avoids underflowing len-1
                right_d = (cur_q == len_q) && ((idx_q + LW'(1)) == len_q);
                state_d = S_CLIP;
            end
            S_CLIP: state_d = ((cur_x_q + ADV) > LIMIT) ? S_IDLE : S_ISSUE;
            S_ISSUE: state_d = S_SETTLE;
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (sd_ready) begin
                    idx_d   = idx_q + LW'(1);
                    cur_x_d = cur_x_q + ADV;
                    state_d = ((idx_q + LW'(1)) < len_q) ? S_FETCH : S_IDLE;
                end
            end
            S_EMPTY: begin
                sym_d   = '0;
                left_d  = 1'b1;
                right_d = 1'b0;
                state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready           = (state_q == S_IDLE);
    assign sd_start        = (state_q == S_ISSUE);
    assign text_read_addr  = idx_q[AW-1:0];
    assign sd_x            = cur_x_q[9:0];
    assign sd_y            = y_q;
    assign sd_symbol       = sym_q;
    assign sd_cursor_left  = left_q;
    assign sd_cursor_right = right_q;

endmodule

// File: tb/tb_text_line_drawer.sv
// Bench for text_line_drawer: RAM and symbol_drawer models, scoreboard of expected glyph jobs.
module tb_text_line_drawer;

    localparam int LW = 6;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic [9:0]    x;
    logic [8:0]    y;
    logic [LW-1:0] length;
    logic [LW-1:0] cursor_pos;
    logic [AW-1:0] text_read_addr;
    logic [6:0]    text_read_data;
    logic          sd_start;
    logic          sd_ready;
    logic [9:0]    sd_x;
    logic [8:0]    sd_y;
    logic [6:0]    sd_symbol;
    logic          sd_cursor_left;
    logic          sd_cursor_right;

    text_line_drawer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .x(x), .y(y), .length(length), .cursor_pos(cursor_pos),
        .text_read_addr(text_read_addr), .text_read_data(text_read_data),
        .sd_start(sd_start), .sd_ready(sd_ready), .sd_x(sd_x), .sd_y(sd_y),
        .sd_symbol(sd_symbol), .sd_cursor_left(sd_cursor_left),
        .sd_cursor_right(sd_cursor_right)
    );

    always #5 clk = ~clk;

    logic [6:0] mem [32];
    always @(posedge clk) text_read_data <= mem[text_read_addr];

    // symbol_drawer model; stale_mode keeps sd_ready high one cycle after sd_start
    bit stale_mode = 1'b0;
    int draw_time  = 3;
    int dcnt;
    bit pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_ready <= 1'b1;
            dcnt     <= 0;
            pend     <= 1'b0;
        end else if (sd_start) begin
            if (stale_mode) pend <= 1'b1;
            else sd_ready <= 1'b0;
            dcnt <= draw_time;
        end else if (pend) begin
            pend     <= 1'b0;
            sd_ready <= 1'b0;
        end else if (!sd_ready) begin
            if (dcnt == 0) sd_ready <= 1'b1;
            else dcnt <= dcnt - 1;
        end
    end

    typedef struct packed {
        logic [9:0] gx;
        logic [8:0] gy;
        logic [6:0] sym;
        logic       l;
        logic       r;
    } glyph_t;

    glyph_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_text(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte b;
            b = s[i];
            mem[i] = b[6:0];
        end
    endtask

    task automatic push_expect(input int x0, input int y0, input int len, input int cur);
        glyph_t g;
        if (len == 0) begin
            g.gx = 10'(x0); g.gy = 9'(y0); g.sym = '0; g.l = 1'b1; g.r = 1'b0;
            exp_q.push_back(g);
        end else begin
            for (int i = 0; i < len; i++) begin
                int cx;
                cx = x0 + 15 * i;
                if (cx + 15 > 640) break;
                g.gx  = 10'(cx);
                g.gy  = 9'(y0);
                g.sym = mem[i];
                g.l   = (cur == i);
                g.r   = (cur == len) && (i == len - 1);
                exp_q.push_back(g);
            end
        end
    endtask

    task automatic start_job(input int x0, input int y0, input int len, input int cur);
        push_expect(x0, y0, len, cur);
        pulses = 0;
        @(negedge clk);
        x = 10'(x0); y = 9'(y0); length = LW'(len); cursor_pos = LW'(cur);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_drop", ready, 0);
    endtask

    task automatic compare_glyph();
        glyph_t g;
        pulses++;
        if (exp_q.size() == 0) begin
            check("extra_sd_start", 1, 0);
        end else begin
            g = exp_q.pop_front();
            check("sd_x", sd_x, g.gx);
            check("sd_y", sd_y, g.gy);
            check("sd_symbol", sd_symbol, g.sym);
            check("cursor_left", sd_cursor_left, g.l);
            check("cursor_right", sd_cursor_right, g.r);
        end
    endtask

    task automatic drain(input int budget, input bit poke, input int exp_pulses);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (sd_start) begin
                compare_glyph();
                if (poke && pulses == 1) begin
                    start = 1'b1; x = 10'd999; y = 9'd5; length = LW'(1); cursor_pos = '0;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            if (ready) done = 1'b1;
        end
        check("job_done", done, 1);
        check("pulse_count", pulses, exp_pulses);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; length = '0; cursor_pos = '0;
        for (int i = 0; i < 32; i++) mem[i] = 7'(i + 48);
        #1;
        check("rst_ready", ready, 1);
        check("rst_sd_start", sd_start, 0);
        check("rst_sd_x", sd_x, 0);
        check("rst_flags", {sd_cursor_left, sd_cursor_right}, 0);
        #20 rst_n = 1'b1;

        load_text("hello");
        start_job(100, 100, 5, 1);
        drain(300, 1'b0, 5);

        load_text("abc");
        start_job(0, 50, 3, 3);
        drain(300, 1'b1, 3);

        start_job(40, 20, 0, 0);
        drain(100, 1'b0, 1);

        load_text("hello");
        start_job(600, 7, 5, 0);
        drain(300, 1'b0, 2);
        repeat (20) @(negedge clk);
        check("clip_no_third", sd_start, 0);
        check("clip_ready", ready, 1);

        stale_mode = 1'b1;
        start_job(10, 200, 5, 5);
        drain(300, 1'b0, 5);
        stale_mode = 1'b0;

        // reset while the second glyph is being drawn
        draw_time = 8;
        start_job(100, 100, 5, 1);
        for (int c = 0; c < 200 && pulses < 2; c++) begin
            @(negedge clk);
            if (sd_start) compare_glyph();
        end
        check("two_pulses", pulses, 2);
        @(negedge clk);
        @(negedge clk);
        check("in_wait_busy", ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", ready, 1);
        check("arst_sd_start", sd_start, 0);
        check("arst_sd_x", sd_x, 0);
        check("arst_sd_y", sd_y, 0);
        check("arst_symbol", sd_symbol, 0);
        check("arst_flags", {sd_cursor_left, sd_cursor_right}, 0);
        check("arst_addr", text_read_addr, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        draw_time = 3;
        start_job(100, 100, 5, 1);
        drain(300, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_line_drawer.md
Name: text_line_drawer

Overview:
- Upstream sequencer for symbol_drawer: renders one line of text from a character buffer by issuing one symbol_drawer job per character.
- Advances x by SYMBOL_ADVANCE per glyph and maps a cursor index onto the cursor_left/cursor_right flags.
- Used by the top level to render the expression input line into frame_buffer after fill_drawer clears it.

Parameters:
- MAX_LEN, 32, capacity of the text buffer in characters; sets the widths of length, cursor_pos and text_read_addr.
- SYMBOL_ADVANCE, 15, x step in pixels between consecutive glyphs.
- SCREEN_WIDTH, 640, horizontal clipping limit in pixels.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only while ready=1.
- ready  out  1  high when idle.
- x  in  10  left pixel x of the first glyph.
- y  in  9  top pixel y of the line.
- length  in  $clog2(MAX_LEN+1)  number of characters to draw, range 0..MAX_LEN.
- cursor_pos  in  $clog2(MAX_LEN+1)  cursor index, range 0..length; the cursor sits before character cursor_pos.
- text_read_addr  out  $clog2(MAX_LEN)  character buffer read address.
- text_read_data  in  7  character code; synchronous read, valid 1 cycle after the address.
- sd_start  out  1  start pulse to symbol_drawer.
- sd_ready  in  1  symbol_drawer ready.
- sd_x  out  10  glyph x to symbol_drawer.
- sd_y  out  9  glyph y to symbol_drawer.
- sd_symbol  out  7  glyph code to symbol_drawer.
- sd_cursor_left  out  1  draw cursor on the left edge of the glyph.
- sd_cursor_right  out  1  draw cursor on the right edge of the glyph.

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready=1; sd_start=0; all other outputs 0.
- Reset mid-operation aborts at once. Reset does not abort a glyph already started in symbol_drawer; the top level resets both blocks.
- On start with ready=1, latch x, y, length and cursor_pos; set index=0; cur_x = x, held as an 11-bit register.
  - ready drops in the following cycle.
  - start while ready=0 is ignored.
- States:
  - IDLE: wait for start. Go to FETCH if length>0, else EMPTY.
  - FETCH: drive text_read_addr=index, held stable. Go to LATCH.
  - LATCH: capture text_read_data into sd_symbol. Go to CLIP.
  - CLIP: if cur_x + SYMBOL_ADVANCE > SCREEN_WIDTH (11-bit compare), go to IDLE and draw no further glyphs; else go to ISSUE.
  - ISSUE: sd_start=1 for exactly this one cycle. sd_x=cur_x[9:0]; sd_y=latched y. Go to SETTLE.
  - SETTLE: one cycle to ignore stale sd_ready. Go to WAIT.
  - WAIT: hold while sd_ready=0. When sd_ready=1: index+=1; cur_x += SYMBOL_ADVANCE. Go to FETCH if index<length, else IDLE.
  - EMPTY: issue a single glyph with code 0 (blank) at x, sd_cursor_left=1, using the ISSUE/SETTLE/WAIT sequence, then go to IDLE.
- Cursor flags for glyph i:
  - sd_cursor_left = (cursor_pos == i).
  - sd_cursor_right = (cursor_pos == length) && (i == length-1).
- sd_x, sd_y, sd_symbol and both cursor flags are stable from ISSUE until WAIT exits.
- Per-glyph overhead: 5 cycles plus the symbol_drawer draw time.
- No arithmetic wraps: cur_x is 11 bits, and a glyph starts only if it ends at or before SCREEN_WIDTH.

Test Plan:
- x=100, y=100, text "hello", length=5, cursor_pos=1:
  - exactly 5 sd_start pulses, at sd_x=100,115,130,145,160, all with sd_y=100;
  - symbols h,e,l,l,o;
  - sd_cursor_left only on 'e', sd_cursor_right never;
  - ready returns to 1 after the 5th sd_ready.
- length=3 ("abc"), cursor_pos=3, x=0: sd_cursor_right=1 only on 'c' at sd_x=30; no sd_cursor_left pulses.
- length=0, x=40, y=20: a single glyph with symbol 0 at (40,20) and sd_cursor_left=1.
- x=600, length=5: glyphs at 600 and 615 only (630+15>640); ready=1 with no third sd_start.
- Busy and sd_ready timing:
  - start pulses while busy change nothing; latched x, y and length are unchanged.
  - A symbol_drawer model that holds sd_ready=1 for one cycle after sd_start does not skip glyphs.
- rst_n=0 during WAIT of the 2nd glyph: outputs 0 and ready=1 immediately (async). A new start then draws from index 0.
